// File: rtl/bcd_pkg.sv
// Shared types and constants for the single-digit BCD counter.
package bcd_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    localparam digit_t BCD_MAX = digit_t'(9);
    localparam digit_t BCD_MIN = digit_t'(0);

    // True when the code is a legal decimal digit.
    function automatic logic is_bcd(input digit_t d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_counter_if.sv
// Control inputs and digit outputs of the BCD digit counter.
interface bcd_digit_counter_if;
    import bcd_pkg::*;

    logic   run;
    logic   step;
    logic   up;
    logic   load;
    digit_t load_val;
    logic   W;
    logic   X;
    logic   Y;
    logic   Z;
    logic   carry;
    logic   tick;

    modport master (
        output run, step, up, load, load_val,
        input  W, X, Y, Z, carry, tick
    );

    modport slave (
        input  run, step, up, load, load_val,
        output W, X, Y, Z, carry, tick
    );

endinterface

// File: rtl/step_conditioner.sv
// Push-button conditioning: 2-flop synchronizer, optional debouncer
// (BCD_DEBOUNCE_EN) and a one-cycle rising-edge pulse.
module step_conditioner #(
    parameter int unsigned DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic step,
    output logic pulse_c
);

    if (DB_CYCLES < 2) begin : g_bad_db_cycles
        $error("step_conditioner: DB_CYCLES must be at least 2");
    end

    logic sync_q1;
    logic sync_q2;
    logic level;
    logic level_q;

    // Metastability guard for the asynchronous button input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= step;
            sync_q2 <= sync_q1;
        end
    end

`ifdef BCD_DEBOUNCE_EN
    localparam int unsigned DB_W = $clog2(DB_CYCLES);

    logic [DB_W-1:0] db_cnt_q;

    // Level follows the synchronized input only after DB_CYCLES disagreeing cycles in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_q <= '0;
            level    <= 1'b0;
        end else if (sync_q2 != level) begin
            if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
                level    <= sync_q2;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + DB_W'(1);
            end
        end else begin
            db_cnt_q <= '0;
        end
    end
`else
    assign level = sync_q2;
`endif

    // Edge register resets low so a button held through reset still counts once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign pulse_c = level & ~level_q;

endmodule

// File: rtl/bcd_digit_counter.sv
// Single-digit BCD up/down counter with auto-run prescaler, button step,
// parallel load and wrap carry. Debounce on the step path: BCD_DEBOUNCE_EN.
module bcd_digit_counter
    import bcd_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned DB_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_digit_counter_if.slave  bus
);

    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("bcd_digit_counter: TICK_DIV must be at least 2");
    end

    localparam int unsigned     PS_W    = $clog2(TICK_DIV);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    logic [PS_W-1:0] ps_q;
    logic            tick_c;
    logic            step_pulse_c;
    logic            count_c;
    digit_t          digit_q;
    digit_t          digit_d;
    logic            carry_q;
    logic            carry_d;

    // Auto-run prescaler; held at zero while run is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_q <= '0;
        end else if (!bus.run || ps_q == PS_LAST) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_q + PS_W'(1);
        end
    end

    assign tick_c = bus.run && (ps_q == PS_LAST);

    step_conditioner #(
        .DB_CYCLES (DB_CYCLES)
    ) u_step_conditioner (
        .clk     (clk),
        .rst_n   (rst_n),
        .step    (bus.step),
        .pulse_c (step_pulse_c)
    );

    // A tick and a step pulse in the same cycle merge into one count.
    assign count_c = tick_c | step_pulse_c;

    // Next digit: load beats counting; an out-of-range load also swallows the count.
    always_comb begin
        digit_d = digit_q;
        carry_d = 1'b0;
        if (bus.load) begin
            if (is_bcd(bus.load_val)) begin
                digit_d = bus.load_val;
            end
        end else if (count_c) begin
            if (bus.up) begin
                if (digit_q == BCD_MAX) begin
                    digit_d = BCD_MIN;
                    carry_d = 1'b1;
                end else begin
                    digit_d = digit_q + digit_t'(1);
                end
            end else begin
                if (digit_q == BCD_MIN) begin
                    digit_d = BCD_MAX;
                    carry_d = 1'b1;
                end else begin
                    digit_d = digit_q - digit_t'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= BCD_MIN;
            carry_q <= 1'b0;
        end else begin
            digit_q <= digit_d;
            carry_q <= carry_d;
        end
    end

    assign bus.W     = digit_q[3];
    assign bus.X     = digit_q[2];
    assign bus.Y     = digit_q[1];
    assign bus.Z     = digit_q[0];
    assign bus.carry = carry_q;
    assign bus.tick  = tick_c;

endmodule
